// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state, op encodings and sign helpers for the multiply/divide unit
package mult_div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Helpers work on the widest value the unit handles (a 2*32-bit product);
   // callers zero-extend into and truncate out of this width.
   localparam int MAX_WIDTH = 64;

   function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] v,
                                                    input logic                 neg);
      return neg ? twos_neg(v) : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/done handshake and HI/LO result bundle
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle signed multiply/divide unit owning HI and LO
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   mult_div_unit_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int DW    = 2 * WIDTH;

   state_e           state_q;
   logic             op_q;
   logic             neg_a_q;
   logic             neg_b_q;
   logic             b_zero_q;
   logic [CNT_W-1:0] cnt_q;
   // MULT: {partial product, remaining multiplier bits}; DIV: low half is dividend in / quotient out
   logic [DW-1:0]    acc_q;
   // MULT: |a| multiplicand; DIV: |b| divisor
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             div_zero_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [DW-1:0]    mul_next;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [DW-1:0]    prod_res;
   logic [WIDTH-1:0] quot_res;
   logic [WIDTH-1:0] rem_res;

   // Operand magnitudes, one iteration step for each op, and sign-corrected results
   always_comb begin
      mag_a     = WIDTH'(abs_val(MAX_WIDTH'(bus.a), bus.a[WIDTH-1]));
      mag_b     = WIDTH'(abs_val(MAX_WIDTH'(bus.b), bus.b[WIDTH-1]));
      mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {rem_q, acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      prod_res  = (neg_a_q ^ neg_b_q) ? DW'(twos_neg(MAX_WIDTH'(acc_q))) : acc_q;
      quot_res  = (neg_a_q ^ neg_b_q) ? WIDTH'(twos_neg(MAX_WIDTH'(acc_q[WIDTH-1:0])))
                                      : acc_q[WIDTH-1:0];
      // Remainder follows the dividend; with b == 0 this reproduces a exactly
      rem_res   = neg_a_q ? WIDTH'(twos_neg(MAX_WIDTH'(rem_q))) : rem_q;
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         op_q       <= OP_MULT;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         b_zero_q   <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  op_q       <= bus.op;
                  neg_a_q    <= bus.a[WIDTH-1];
                  neg_b_q    <= bus.b[WIDTH-1];
                  b_zero_q   <= (bus.b == '0);
                  cnt_q      <= CNT_W'(WIDTH - 1);
                  rem_q      <= '0;
                  busy_q     <= 1'b1;
                  div_zero_q <= 1'b0;
                  if (bus.op == OP_DIV) begin
                     acc_q  <= {{WIDTH{1'b0}}, mag_a};
                     opnd_q <= mag_b;
                  end else begin
                     acc_q  <= {{WIDTH{1'b0}}, mag_b};
                     opnd_q <= mag_a;
                  end
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (op_q == OP_MULT) begin
                  acc_q <= mul_next;
               end else if (!div_diff[WIDTH]) begin
                  rem_q <= div_diff[WIDTH-1:0];
                  acc_q <= {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= div_shift[WIDTH-1:0];
                  acc_q <= {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_q <= FINISH;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FINISH: begin
               if (op_q == OP_MULT) begin
                  hi_q <= prod_res[DW-1:WIDTH];
                  lo_q <= prod_res[WIDTH-1:0];
               end else begin
                  hi_q <= rem_res;
                  lo_q <= b_zero_q ? {WIDTH{1'b1}} : quot_res;
               end
               div_zero_q <= (op_q == OP_DIV) && b_zero_q;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   tests = 0;
   int   fails = 0;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: signed arithmetic on 64-bit integers; result = {div_zero, hi, lo}
   function automatic logic [64:0] ref_model(input logic o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint r;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      if (o == 1'b0) begin
         p = sa * sb;
         return {1'b0, p};
      end
      if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 45; i++) begin
         if (bus.done) begin
            lat = cyc - acc_cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input logic [64:0] exp);
      int lat;
      issue(o, x, y);
      chk({tag, " busy"}, 64'(bus.busy), 64'(1));
      wait_done(lat);
      chk({tag, " latency"}, 64'(lat), 64'(33));
      chk({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
      chk({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
      chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp[64]));
      chk({tag, " busy_low"}, 64'(bus.busy), 64'(0));
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, 64'(bus.done), 64'(0));
   endtask

   initial begin
      int lat;
      int pulses;
      logic o;
      logic [31:0] x;
      logic [31:0] y;

      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 64'(bus.busy), 64'(0));
      chk("reset done", 64'(bus.done), 64'(0));
      chk("reset div_zero", 64'(bus.div_zero), 64'(0));
      chk("reset hi", 64'(bus.hi), 64'(0));
      chk("reset lo", 64'(bus.lo), 64'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("mul 7x6", 1'b0, 32'd7, 32'd6, {1'b0, 32'h0, 32'h2A});
      do_op("mul -3x5", 1'b0, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      do_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0});
      do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000});
      do_op("div by zero", 1'b1, 32'h1234, 32'h0, {1'b1, 32'h1234, 32'hFFFF_FFFF});

      issue(1'b0, 32'd3, 32'd3);
      chk("div_zero cleared", 64'(bus.div_zero), 64'(0));
      wait_done(lat);
      chk("after dz lo", 64'(bus.lo), 64'(9));

      @(posedge clk);
      #1;
      issue(1'b0, 32'd7, 32'd6);
      repeat (9) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 1'b1;
      bus.a     = 32'd100;
      bus.b     = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      chk("ignored start latency", 64'(lat), 64'(33));
      chk("ignored start lo", 64'(bus.lo), 64'(42));
      chk("ignored start hi", 64'(bus.hi), 64'(0));
      issue(1'b0, 32'hFFFF_FFFE, 32'd9);
      chk("b2b busy", 64'(bus.busy), 64'(1));
      chk("b2b done low", 64'(bus.done), 64'(0));
      wait_done(lat);
      chk("b2b latency", 64'(lat), 64'(33));
      chk("b2b hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
      chk("b2b lo", 64'(bus.lo), 64'(32'hFFFF_FFEE));
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) begin
         o = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       x = 32'h8000_0000;
            1:       x = 32'hFFFF_FFFF;
            2:       x = 32'h0;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       y = 32'h8000_0000;
            1:       y = 32'hFFFF_FFFF;
            2:       y = 32'h0;
            default: y = $urandom;
         endcase
         do_op($sformatf("rand%0d %s %h %h", i, o ? "div" : "mul", x, y), o, x, y,
               ref_model(o, x, y));
      end

      issue(1'b1, 32'd1000, 32'd7);
      repeat (19) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort busy", 64'(bus.busy), 64'(0));
      chk("abort hi", 64'(bus.hi), 64'(0));
      chk("abort lo", 64'(bus.lo), 64'(0));
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) pulses++;
         @(posedge clk);
         #1;
      end
      chk("abort no done", 64'(pulses), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
